// File: rtl/traffic_light_sequencer.sv
// Timed RED -> GREEN -> YELLOW phase sequencer feeding the traffic-light control unit.
// Define TRAFFIC_PED_SERVICE_EN to enable pedestrian early-exit from GREEN and ped_ack.
module traffic_light_sequencer #(
    parameter int RED_CYCLES    = 20,
    parameter int GREEN_CYCLES  = 30,
    parameter int YELLOW_CYCLES = 5,
    parameter int MIN_GREEN     = 10,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             ped_req,
    output logic [1:0]       sw_traffic_lights,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] timer,
    output logic             ped_ack
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RED    = 2'd1,
        GREEN  = 2'd2,
        YELLOW = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_CYCLES - 1);
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] timer_nxt;
    logic [CNT_W-1:0] phase_last;
    logic [1:0]       sw_nxt;
    logic             ack_nxt;
    logic             ped_exit;
    logic             green_exit;

`ifdef TRAFFIC_PED_SERVICE_EN
    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);

    logic ped_pending, pending_nxt;
    logic ped_seen;

    // A request arriving on the exit cycle itself counts as served by that exit.
    assign ped_seen = ped_pending | ped_req;
    assign ped_exit = (state == GREEN) && ped_seen && (timer >= MIN_LAST);
`else
    logic unused_ped_req;

    assign unused_ped_req = ped_req;
    assign ped_exit       = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            timer             <= '0;
            sw_traffic_lights <= 2'b01;
            ped_ack           <= 1'b0;
        end else begin
            state             <= state_nxt;
            timer             <= timer_nxt;
            sw_traffic_lights <= sw_nxt;
            ped_ack           <= ack_nxt;
        end
    end

`ifdef TRAFFIC_PED_SERVICE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ped_pending <= 1'b0;
        else       ped_pending <= pending_nxt;
    end
`endif

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        phase_last = RED_LAST;

        case (state)
            RED:     phase_last = RED_LAST;
            GREEN:   phase_last = GREEN_LAST;
            YELLOW:  phase_last = YELLOW_LAST;
            IDLE:    phase_last = RED_LAST;
        endcase

        if (enable) begin
            case (state)
                IDLE: begin
                    state_nxt = RED;
                    timer_nxt = '0;
                end
                RED, GREEN, YELLOW: begin
                    if (timer == phase_last || ped_exit) begin
                        timer_nxt = '0;
                        case (state)
                            RED:     state_nxt = GREEN;
                            GREEN:   state_nxt = YELLOW;
                            YELLOW:  state_nxt = RED;
                            IDLE:    state_nxt = RED;
                        endcase
                    end else begin
                        timer_nxt = timer + CNT_W'(1);
                    end
                end
            endcase
        end

        // Control unit must see Red while the sequencer is still idle.
        sw_nxt     = (state_nxt == IDLE) ? 2'b01 : state_nxt;
        green_exit = (state == GREEN) && (state_nxt == YELLOW);
    end

`ifdef TRAFFIC_PED_SERVICE_EN
    always_comb begin
        ack_nxt     = green_exit && ped_seen;
        pending_nxt = green_exit ? 1'b0 : ped_seen;
    end
`else
    always_comb begin
        ack_nxt = 1'b0;
        if (green_exit) ack_nxt = 1'b0;
    end
`endif

    assign phase = state;

endmodule

// File: doc/traffic_light_sequencer.md
Name: traffic_light_sequencer

Overview:
Timed phase sequencer that drives the 2-bit `sw_traffic_lights` command into the traffic-light control unit. It cycles RED -> GREEN -> YELLOW with parameterised per-phase durations. A pedestrian request ends GREEN early, once a minimum green time has passed. It sits between the board-level inputs and the control unit and owns all phase timing.

Parameters:
- RED_CYCLES, 20, RED phase length in enabled clock cycles (>=1)
- GREEN_CYCLES, 30, nominal GREEN phase length in enabled cycles (>=1)
- YELLOW_CYCLES, 5, YELLOW phase length in enabled cycles (>=1)
- MIN_GREEN, 10, minimum GREEN cycles before a pedestrian early exit (1..GREEN_CYCLES)
- CNT_W, 8, phase counter width; every duration must be <= 2^CNT_W

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- enable  input  1  1 = sequencing runs; 0 = pause (state and counter hold)
- ped_req  input  1  pedestrian request, sampled every clock
- sw_traffic_lights  output  2  command to control unit: 01 Red, 10 Green, 11 Yellow
- phase  output  2  current FSM state: 0 IDLE, 1 RED, 2 GREEN, 3 YELLOW
- timer  output  CNT_W  cycles elapsed in the current phase (0-based)
- ped_ack  output  1  one-cycle pulse when a pedestrian request is served

Behaviour:
- All outputs are registered.
- Reset (asynchronous, immediate):
  - phase = IDLE, timer = 0, ped_ack = 0, ped_pending = 0
  - sw_traffic_lights = 01
- sw_traffic_lights encoding:
  - equals `phase` in RED, GREEN and YELLOW
  - equals 01 in IDLE, so the control unit holds Red after its own reset
- IDLE: waits for enable = 1, then enters RED on the next edge with timer = 0.
- Phase counter:
  - On every enabled cycle in RED, GREEN or YELLOW, timer increments.
  - On a phase transition edge, timer loads 0.
  - Phase X ends on the enabled cycle where timer == X_CYCLES-1, so each phase lasts exactly X_CYCLES enabled cycles.
- Transitions:
  - RED -> GREEN
  - GREEN -> YELLOW
  - YELLOW -> RED
  - The FSM never returns to IDLE except via reset.
- Pause: with enable = 0, state, timer and sw_traffic_lights hold. ped_req is still latched into ped_pending.
- Pedestrian service:
  - ped_pending is set on any cycle where ped_req = 1, in every state, including while paused.
  - Early exit: in GREEN, when enable = 1, ped_pending = 1 and timer >= MIN_GREEN-1, the FSM goes to YELLOW at the next edge.
  - ped_pending is cleared on every GREEN -> YELLOW edge, whether the exit was normal or early. Clear has priority over a coincident ped_req; that request is treated as served.
  - ped_ack is 1 for exactly the first YELLOW cycle when ped_pending was 1 at the GREEN -> YELLOW edge; otherwise it is 0.
- Boundary cases:
  - If the nominal end (timer == GREEN_CYCLES-1) and the early-exit condition coincide, there is a single transition and ped_ack pulses.
  - With MIN_GREEN == GREEN_CYCLES, a request never shortens GREEN but is still acknowledged.
- Timing: the control unit registers sw_traffic_lights, so its lamp output lags `phase` by one cycle. No handshake back from the control unit is used.

Optional Feature:
- Macro: TRAFFIC_PED_SERVICE_EN
- Defined: pedestrian logic behaves as described above.
- Undefined:
  - ped_req port remains but is ignored.
  - ped_pending logic is removed and ped_ack is tied to 0.
  - GREEN always lasts GREEN_CYCLES.

Test Plan:
1. Reset pulse, then enable = 1 held (defaults) -> one IDLE cycle (sw = 01), then RED 20 cycles (01), GREEN 30 (10), YELLOW 5 (11), repeating with period 55; timer runs 0..19, 0..29, 0..4.
2. ped_req 1-cycle pulse at GREEN timer = 3 -> GREEN ends after timer = 9 (10 cycles); YELLOW entered with ped_ack = 1 for one cycle.
3. ped_req pulse at GREEN timer = 15 -> YELLOW on the next edge (GREEN lasts 16 cycles); ped_ack pulse; the following GREEN lasts a full 30 cycles.
4. ped_req pulse during RED timer = 5 -> next GREEN lasts exactly 10 cycles, ped_ack at YELLOW entry.
5. enable = 0 for 7 cycles at GREEN timer = 12 -> sw holds 10 and timer holds 12; after resume, GREEN totals 30 enabled cycles.
6. reset asserted asynchronously mid-YELLOW with ped_pending = 1 -> outputs go to IDLE values immediately, without waiting for a clock edge; after release, the next GREEN lasts the full 30 cycles.
